// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM request arbiter: widths, FSM encoding and
// the command bytes used by the downstream QPI PSRAM controller.
package psram_pkg;

    localparam int PSRAM_ADDR_W  = 24;
    localparam int PSRAM_DATA_W  = 16;
    localparam int PSRAM_TIMEOUT = 64;
    localparam int PSRAM_NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [7:0] CMD_RST_EN = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_WRITE  = 8'h02;

endpackage

// File: rtl/psram_rr_arb2.sv
// Two-input round-robin picker: a lone request always wins; on contention the
// requester that was not served last wins.
module psram_rr_arb2
    import psram_pkg::*;
(
    input  logic [PSRAM_NUM_REQ-1:0] req,
    input  logic                     last,
    output logic [PSRAM_NUM_REQ-1:0] win
);

    always_comb begin
        win = '0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/psram_arbiter.sv
// Arbitrates two single-transaction requesters onto one PSRAM controller,
// holding the read/write command level until mem_done or a timeout.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int ADDR_W  = PSRAM_ADDR_W,
    parameter int DATA_W  = PSRAM_DATA_W,
    parameter int TIMEOUT = PSRAM_TIMEOUT
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              read_sw,
    output logic              write_sw,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] data_out
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              read_sw_q, read_sw_d;
    logic              write_sw_q, write_sw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0] req;
    logic [1:0] win;

    assign req = {req1, req0};

    // last_q doubles as the owner of the transaction in flight
    psram_rr_arb2 u_arb (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        read_sw_d  = read_sw_q;
        write_sw_d = write_sw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (init_done && (|req)) begin
                    gnt_d      = win;
                    last_d     = win[1];
                    we_d       = win[1] ? we1 : we0;
                    addr_d     = win[1] ? addr1 : addr0;
                    wdata_d    = win[1] ? wdata1 : wdata0;
                    read_sw_d  = ~we_d;
                    write_sw_d = we_d;
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // a completion on the expiry cycle still counts as success
                if (mem_done || (cnt_q == CNT_LAST)) begin
                    read_sw_d  = 1'b0;
                    write_sw_d = 1'b0;
                    done_d     = last_q ? 2'b10 : 2'b01;
                    err_d      = ~mem_done;
                    if (mem_done && !we_q) begin
                        rdata_d = data_out;
                    end
                    state_d    = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                read_sw_d  = 1'b0;
                write_sw_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            read_sw_q  <= 1'b0;
            write_sw_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            read_sw_q  <= read_sw_d;
            write_sw_q <= write_sw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign read_sw  = read_sw_q;
    assign write_sw = write_sw_q;
    assign address  = addr_q;
    assign data_in  = wdata_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench: a default-TIMEOUT arbiter and a TIMEOUT=8 copy share stimulus;
// each task drives one scenario and checks hand-computed values on the falling edge.
module tb_psram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          mem_clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, data_out = '0;
    logic          mem_done = 1'b0;

    logic          gnt0, gnt1, done0, done1, err, busy, read_sw, write_sw;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in, rdata;
    logic          t_gnt0, t_gnt1, t_done0, t_done1, t_err, t_busy, t_read_sw, t_write_sw;
    logic [AW-1:0] t_address;
    logic [DW-1:0] t_data_in, t_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 mem_clk = ~mem_clk;

    psram_arbiter dut (
        .mem_clk(mem_clk), .rst(rst), .init_done(init_done),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata(rdata), .busy(busy), .read_sw(read_sw), .write_sw(write_sw),
        .address(address), .data_in(data_in),
        .mem_done(mem_done), .data_out(data_out)
    );

    psram_arbiter #(.TIMEOUT(8)) dut_to (
        .mem_clk(mem_clk), .rst(rst), .init_done(init_done),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(t_gnt0), .gnt1(t_gnt1), .done0(t_done0), .done1(t_done1), .err(t_err),
        .rdata(t_rdata), .busy(t_busy), .read_sw(t_read_sw), .write_sw(t_write_sw),
        .address(t_address), .data_in(t_data_in),
        .mem_done(mem_done), .data_out(data_out)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge mem_clk);
        n_cmp++;
        if ({gnt0, gnt1, done0, done1, err, busy, read_sw, write_sw} !== 8'b0 ||
            address !== '0 || data_in !== '0 || rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_main: ctl=%b addr=%h din=%h rdata=%h (want all zero)",
                     {gnt0, gnt1, done0, done1, err, busy, read_sw, write_sw}, address, data_in, rdata);
        end
        n_cmp++;
        if ({t_gnt0, t_gnt1, t_done0, t_done1, t_err, t_busy, t_read_sw, t_write_sw} !== 8'b0 ||
            t_address !== '0 || t_data_in !== '0 || t_rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_to: ctl=%b addr=%h din=%h rdata=%h (want all zero)",
                     {t_gnt0, t_gnt1, t_done0, t_done1, t_err, t_busy, t_read_sw, t_write_sw},
                     t_address, t_data_in, t_rdata);
        end
        rst = 1'b0;
        init_done = 1'b1;
    endtask

    task automatic test_read();
        int hi;
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000100;
        @(negedge mem_clk);
        n_cmp++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || read_sw !== 1'b1 || write_sw !== 1'b0 ||
            busy !== 1'b1 || address !== 24'h000100 || t_gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL read_grant: gnt=%b%b sw=%b%b busy=%b addr=%h t_gnt0=%b (want 01 10 1 000100 1)",
                     gnt1, gnt0, read_sw, write_sw, busy, address, t_gnt0);
        end
        req0 = 1'b0;
        hi = 1;
        for (int k = 2; k <= 20; k++) begin
            @(negedge mem_clk);
            if (read_sw === 1'b1) hi++;
            if (k == 9) begin
                n_cmp++;
                if (t_done0 !== 1'b1 || t_err !== 1'b1) begin
                    n_bad++;
                    $display("FAIL read_to8_expiry: t_done0=%b t_err=%b (want 1 1)", t_done0, t_err);
                end
            end
            if (k == 20) begin
                mem_done = 1'b1;
                data_out = 16'hABCD;
            end
        end
        @(negedge mem_clk);
        mem_done = 1'b0;
        n_cmp++;
        if (hi !== 20) begin
            n_bad++;
            $display("FAIL read_sw_len: got %0d cycles want 20", hi);
        end
        n_cmp++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || err !== 1'b0 || rdata !== 16'hABCD ||
            read_sw !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL read_done: done=%b%b err=%b rdata=%h sw=%b busy=%b (want 01 0 abcd 0 1)",
                     done1, done0, err, rdata, read_sw, busy);
        end
        n_cmp++;
        if (t_done0 !== 1'b0 || t_rdata !== 16'h0000) begin
            n_bad++;
            $display("FAIL idle_mem_done_ignored: t_done0=%b t_rdata=%h (want 0 0000)", t_done0, t_rdata);
        end
        @(negedge mem_clk);
        n_cmp++;
        if (busy !== 1'b0 || done0 !== 1'b0) begin
            n_bad++;
            $display("FAIL read_idle: busy=%b done0=%b (want 0 0)", busy, done0);
        end
    endtask

    task automatic test_write();
        int stable;
        req1 = 1'b1; we1 = 1'b1; addr1 = 24'h00FFFF; wdata1 = 16'h1234;
        @(negedge mem_clk);
        n_cmp++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || write_sw !== 1'b1 || read_sw !== 1'b0 ||
            address !== 24'h00FFFF || data_in !== 16'h1234) begin
            n_bad++;
            $display("FAIL write_grant: gnt=%b%b sw=%b%b addr=%h din=%h (want 10 01 00ffff 1234)",
                     gnt1, gnt0, read_sw, write_sw, address, data_in);
        end
        req1 = 1'b0; we1 = 1'b0; addr1 = 24'h123456; wdata1 = 16'hDEAD;
        stable = 0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge mem_clk);
            if (write_sw === 1'b1 && address === 24'h00FFFF && data_in === 16'h1234) stable++;
            if (k == 5) begin
                mem_done = 1'b1;
                data_out = 16'h7777;
            end
        end
        @(negedge mem_clk);
        mem_done = 1'b0;
        n_cmp++;
        if (stable !== 4) begin
            n_bad++;
            $display("FAIL write_hold: stable %0d cycles want 4", stable);
        end
        n_cmp++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || err !== 1'b0 || write_sw !== 1'b0 ||
            rdata !== 16'hABCD) begin
            n_bad++;
            $display("FAIL write_done: done=%b%b err=%b wsw=%b rdata=%h (want 10 0 0 abcd)",
                     done1, done0, err, write_sw, rdata);
        end
        @(negedge mem_clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL write_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_contention();
        int       cyc, prev;
        logic     seen, even;
        logic [DW-1:0] exp_rd;
        cyc = 0; prev = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000200;
        req1 = 1'b1; we1 = 1'b1; addr1 = 24'h000300; wdata1 = 16'h4321;
        for (int t = 0; t < 4; t++) begin
            even = (t % 2 == 0);
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                @(negedge mem_clk);
                cyc++;
                seen = gnt0 | gnt1;
            end
            n_cmp++;
            if (!seen || gnt0 !== even || gnt1 !== !even || read_sw !== even || write_sw !== !even) begin
                n_bad++;
                $display("FAIL contention_grant_%0d: gnt=%b%b sw=%b%b (want gnt0=%b)",
                         t, gnt1, gnt0, read_sw, write_sw, even);
            end
            if (t > 0) begin
                n_cmp++;
                if (cyc - prev !== 5) begin
                    n_bad++;
                    $display("FAIL contention_spacing_%0d: got %0d cycles want 5", t, cyc - prev);
                end
            end
            prev = cyc;
            @(negedge mem_clk); cyc++;
            @(negedge mem_clk); cyc++;
            mem_done = 1'b1;
            data_out = 16'h5A00 + 16'(t);
            @(negedge mem_clk); cyc++;
            mem_done = 1'b0;
            exp_rd = even ? 16'h5A00 + 16'(t) : 16'h5A00 + 16'(t - 1);
            n_cmp++;
            if (done0 !== even || done1 !== !even || err !== 1'b0 || read_sw !== 1'b0 ||
                write_sw !== 1'b0 || busy !== 1'b1 || rdata !== exp_rd) begin
                n_bad++;
                $display("FAIL contention_done_%0d: done=%b%b err=%b sw=%b%b busy=%b rdata=%h (want rdata %h)",
                         t, done1, done0, err, read_sw, write_sw, busy, rdata, exp_rd);
            end
            if (t == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        @(negedge mem_clk);
        n_cmp++;
        if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_bad++;
            $display("FAIL contention_end: busy=%b gnt=%b%b (want 0 00)", busy, gnt1, gnt0);
        end
    endtask

    task automatic test_timeout();
        logic early, seen_done, seen_err;
        int   done_k;
        // completion on the expiry cycle of the TIMEOUT=8 copy
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000400;
        @(negedge mem_clk);
        n_cmp++;
        if (t_gnt0 !== 1'b1 || t_read_sw !== 1'b1) begin
            n_bad++;
            $display("FAIL to_edge_grant: t_gnt0=%b t_read_sw=%b (want 1 1)", t_gnt0, t_read_sw);
        end
        req0 = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge mem_clk);
            if (k == 8) begin
                mem_done = 1'b1;
                data_out = 16'hBEEF;
            end
        end
        @(negedge mem_clk);
        mem_done = 1'b0;
        n_cmp++;
        if (t_done0 !== 1'b1 || t_err !== 1'b0 || t_rdata !== 16'hBEEF || done0 !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL to_edge_done: t_done0=%b t_err=%b t_rdata=%h done0=%b err=%b (want 1 0 beef 1 0)",
                     t_done0, t_err, t_rdata, done0, err);
        end
        repeat (2) @(negedge mem_clk);
        // no mem_done at all
        req0 = 1'b1; addr0 = 24'h000500;
        @(negedge mem_clk);
        n_cmp++;
        if (t_gnt0 !== 1'b1 || gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL to_grant: t_gnt0=%b gnt0=%b (want 1 1)", t_gnt0, gnt0);
        end
        req0 = 1'b0;
        early = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge mem_clk);
            if (t_done0 !== 1'b0) early = 1'b1;
        end
        @(negedge mem_clk);
        n_cmp++;
        if (early || t_done0 !== 1'b1 || t_err !== 1'b1 || t_rdata !== 16'hBEEF || t_read_sw !== 1'b0) begin
            n_bad++;
            $display("FAIL to_expiry: early=%b t_done0=%b t_err=%b t_rdata=%h t_read_sw=%b (want 0 1 1 beef 0)",
                     early, t_done0, t_err, t_rdata, t_read_sw);
        end
        seen_done = 1'b0; seen_err = 1'b0; done_k = 0;
        for (int k = 10; k < 110 && (busy || t_busy); k++) begin
            @(negedge mem_clk);
            if (done0 === 1'b1 && !seen_done) begin
                seen_done = 1'b1;
                seen_err = err;
                done_k = k;
            end
        end
        n_cmp++;
        if (!seen_done || seen_err !== 1'b1 || done_k !== 65 || busy !== 1'b0 || rdata !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL to64_expiry: seen=%b err=%b at=%0d busy=%b rdata=%h (want 1 1 65 0 beef)",
                     seen_done, seen_err, done_k, busy, rdata);
        end
    endtask

    task automatic test_init_gate_reset();
        int ng;
        init_done = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000600;
        ng = 0;
        repeat (4) begin
            @(negedge mem_clk);
            if (gnt0 !== 1'b0 || t_gnt0 !== 1'b0 || busy !== 1'b0) ng++;
        end
        n_cmp++;
        if (ng !== 0) begin
            n_bad++;
            $display("FAIL init_block: %0d cycles with grant/busy, want 0", ng);
        end
        init_done = 1'b1;
        @(negedge mem_clk);
        n_cmp++;
        if (gnt0 !== 1'b1 || read_sw !== 1'b1) begin
            n_bad++;
            $display("FAIL init_grant: gnt0=%b read_sw=%b (want 1 1)", gnt0, read_sw);
        end
        req0 = 1'b0;
        @(negedge mem_clk);
        @(negedge mem_clk);
        rst = 1'b1;
        @(negedge mem_clk);
        n_cmp++;
        if (read_sw !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0 || address !== '0 ||
            t_read_sw !== 1'b0 || t_done0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: read_sw=%b busy=%b done0=%b addr=%h t_sw=%b t_done0=%b (want 0 0 0 0 0 0)",
                     read_sw, busy, done0, address, t_read_sw, t_done0);
        end
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr0 = 24'h000700;
        @(negedge mem_clk);
        n_cmp++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || done0 !== 1'b0 || address !== 24'h000700) begin
            n_bad++;
            $display("FAIL post_reset_grant: gnt=%b%b done0=%b addr=%h (want 01 0 000700)",
                     gnt1, gnt0, done0, address);
        end
        req0 = 1'b0; req1 = 1'b0;
        init_done = 1'b0;
        @(negedge mem_clk);
        mem_done = 1'b1;
        data_out = 16'h0F0F;
        @(negedge mem_clk);
        mem_done = 1'b0;
        n_cmp++;
        if (done0 !== 1'b1 || err !== 1'b0 || rdata !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL init_drop_no_abort: done0=%b err=%b rdata=%h (want 1 0 0f0f)", done0, err, rdata);
        end
        init_done = 1'b1;
        repeat (2) @(negedge mem_clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_timeout();
        test_init_gate_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
